// File: rtl/adsr_envelope_pkg.sv
// Shared types and constants for the ADSR envelope: state encodings, the unity level,
// and the Q15 sample scaler.
package adsr_envelope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam logic [14:0] LEVEL_MAX = 15'h7FFF;

  // The product always fits in 31 bits, so the 16-bit result needs no saturation.
  function automatic logic [15:0] scale(input logic signed [15:0] s, input logic [14:0] lvl);
    return 16'((32'(s) * 32'($signed({1'b0, lvl}))) >>> 15);
  endfunction

endpackage

// File: rtl/dffr.sv
// Reset flop with load enable. Synchronous active-high reset has priority over the enable.
// Latency is one cycle, and there is no backpressure.
module dffr #(
  parameter int            W   = 1,
  parameter logic [W-1:0]  RST = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= RST;
    else if (en) q <= d;
  end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator. It scales each valid input sample by the current level (Q15).
// The output is registered with one cycle of latency, and there is no backpressure.
module adsr_envelope
  import adsr_envelope_pkg::*;
#(
  parameter int ATTACK_STEP   = 64,
  parameter int DECAY_STEP    = 16,
  parameter int SUSTAIN_LEVEL = 24576,
  parameter int RELEASE_STEP  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               note_start,
  input  logic               note_release,
  input  logic signed [15:0] sample_in,
  input  logic               sample_in_valid,
  output logic signed [15:0] sample_out,
  output logic               sample_out_valid,
  output logic [14:0]        env_level,
  output logic               busy
);

  localparam logic [15:0] ATK16 = 16'(ATTACK_STEP);
  localparam logic [15:0] DEC16 = 16'(DECAY_STEP);
  localparam logic [15:0] REL16 = 16'(RELEASE_STEP);
  localparam logic [15:0] SUS16 = 16'(SUSTAIN_LEVEL);

  logic [2:0]  state_q;
  state_t      state;
  state_t      state_nxt;
  logic [14:0] level;
  logic [14:0] level_nxt;
  logic [15:0] sum_atk;
  logic [15:0] diff_dec;
  logic [15:0] diff_rel;
  logic [15:0] scaled;

  assign state = state_t'(state_q);

  // State register
  dffr #(.W(3), .RST(3'(ST_IDLE))) u_state (
    .clk(clk), .reset(reset), .en(1'b1), .d(3'(state_nxt)), .q(state_q)
  );

  dffr #(.W(15), .RST(15'd0)) u_level (
    .clk(clk), .reset(reset), .en(1'b1), .d(level_nxt), .q(level)
  );

  // Next-state and level update.
  // The differences are read as signed values, so an underflow shows up as a negative number.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    sum_atk   = {1'b0, level} + ATK16;
    diff_dec  = {1'b0, level} - DEC16;
    diff_rel  = {1'b0, level} - REL16;
    if (note_start) begin
      state_nxt = ST_ATTACK;
    end else if (note_release) begin
      if (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN)
        state_nxt = ST_RELEASE;
    end else if (sample_in_valid) begin
      case (state)
        ST_ATTACK: begin
          if (sum_atk >= {1'b0, LEVEL_MAX}) begin
            level_nxt = LEVEL_MAX;
            state_nxt = ST_DECAY;
          end else begin
            level_nxt = sum_atk[14:0];
          end
        end
        ST_DECAY: begin
          if ($signed(diff_dec) <= $signed(SUS16)) begin
            level_nxt = SUS16[14:0];
            state_nxt = ST_SUSTAIN;
          end else begin
            level_nxt = diff_dec[14:0];
          end
        end
        ST_SUSTAIN: level_nxt = SUS16[14:0];
        ST_RELEASE: begin
          if ($signed(diff_rel) <= 16'sd0) begin
            level_nxt = 15'd0;
            state_nxt = ST_IDLE;
          end else begin
            level_nxt = diff_rel[14:0];
          end
        end
        default: level_nxt = 15'd0;
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy      = (state != ST_IDLE);
    env_level = level;
    scaled    = scale(sample_in, level);
  end

  dffr #(.W(16), .RST(16'd0)) u_sample_out (
    .clk(clk), .reset(reset), .en(sample_in_valid), .d(scaled), .q(sample_out)
  );

  dffr #(.W(1), .RST(1'b0)) u_sample_vld (
    .clk(clk), .reset(reset), .en(1'b1), .d(sample_in_valid), .q(sample_out_valid)
  );

endmodule
